fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly downstream of the 8-bit program ROM. It owns the program counter and drives the ROM address. It also presents the returned instruction to decode/execute and resolves the ISA's relative branches (`branch`/`branchb`) and `halt`. Programs are launched by a start handshake with an entry address (e.g. 0, 100, 152), and completion is reported by a level-sensitive done flag.

## Interface
- `PC_W`, default 8: program counter / ROM address width.
- `CNT_W`, default 16: retired-instruction counter width.

Ports:
- `clk_i`, in, 1: single clock; all state updates on the rising edge.
- `rst_ni`, in, 1: reset, asynchronous and active-low.
- `start_i`, in, 1: launch request; accepted only in IDLE or HALT.
- `start_addr_i`, in, PC_W: entry address, loaded into the PC when start is accepted.
- `stall_i`, in, 1: downstream hold; freezes the PC and counter for this cycle.
- `inst_i`, in, 8: instruction from the ROM; combinational function of `pc_o`.
- `cond_i`, in, 1: branch condition flag from execute (result of last `seq`/`slt`).
- `reg_data_i`, in, 8: register-file value of register `inst_i[2:0]`, combinational.
- `pc_o`, out, PC_W: ROM address; reset value 0.
- `inst_o`, out, 8: equals `inst_i`; decode must ignore it unless `inst_valid_o` is 1.
- `inst_valid_o`, out, 1: 1 only in RUN; reset value 0.
- `done_o`, out, 1: 1 in HALT; reset value 0.
- `error_o`, out, 1: sequential PC overflow past 255; sticky until the next start; reset value 0.
- `inst_count_o`, out, CNT_W: retired instructions since the last start, saturating; reset value 0.

## Operation
- **States:**
  - IDLE (the reset state).
  - RUN.
  - HALT.
- **IDLE/HALT + `start_i`** → RUN.
  - PC ← `start_addr_i`.
  - `inst_count_o` ← 0, `error_o` ← 0, `done_o` ← 0.
- **`start_i` while in RUN** is ignored (no restart, no counter clear).
- **A cycle in RUN with `stall_i` = 0 retires the current `inst_i`:**
  - `halt` (8'h88): go to HALT. PC holds at the halt address. The counter increments; the halt instruction itself counts.
  - `branch rN` (`inst_i[7:3]` = 5'b11110) with `cond_i` = 1: next PC = PC + `reg_data_i`, modulo 256.
  - `branchb rN` (`inst_i[7:3]` = 5'b10110) with `cond_i` = 1: next PC = PC − `reg_data_i`, modulo 256.
  - Branch with `cond_i` = 0: next PC = PC + 1.
  - All other opcodes: next PC = PC + 1.
- **A taken branch with offset 0** yields next PC = PC (self-loop). This is legal and the bench must not flag it.
- **Branch target arithmetic** wraps silently and never sets `error_o`.
- **Sequential increment at PC = 255** (non-halt, not-taken or non-branch):
  - PC wraps to 0.
  - `error_o` ← 1.
  - The state goes to HALT (`done_o` = 1).
- **`inst_count_o`** increments once per retired instruction and saturates at all-ones.
- **`stall_i` in RUN:** PC, counter and state hold. `inst_valid_o` stays 1.
- **`stall_i` in IDLE/HALT** has no effect.
- **Reset asserted at any time:** all outputs return to their reset values immediately (asynchronous). The state returns to IDLE.

## Timing
- The ROM is combinational, so the instruction is available in the same cycle as `pc_o`. Throughput is one instruction per unstalled cycle.
- Start is accepted on edge N; `pc_o` = `start_addr_i` and `inst_valid_o` = 1 from edge N onward.
- The first instruction retires at edge N+1 (if unstalled).
- Branch resolution has zero bubbles: the target PC appears at the edge that retires the branch.
- Halt retires at edge H; `done_o` = 1 and `inst_valid_o` = 0 from edge H.
- `cond_i` and `reg_data_i` are sampled only at the retiring edge. They must be stable during the cycle in which the branch sits on `inst_i`.
- Reset deassertion is synchronised externally; the first edge with `rst_ni` = 1 may accept start.

## Structure
- **Shared package `cpu_pkg`:**
  - State enum (IDLE/RUN/HALT).
  - `OP_HALT` = 8'h88.
  - `OP_BR_FWD` = 5'b11110.
  - `OP_BR_BWD` = 5'b10110.
  - Widths `PC_W`/`INST_W`.
- **One combinational sub-module, `next_pc_calc`:**
  - Inputs: pc, inst, cond, reg_data.
  - Outputs: next_pc, is_halt, seq_overflow.
- The FSM, PC register, counter and flags live in `fetch_unit`.

## Test plan
- Reset mid-RUN at PC = 37 → `pc_o` = 0, `inst_valid_o` = 0, `done_o` = 0, `inst_count_o` = 0 immediately, before the next clock edge.
- Start with addr 0 against the real ROM; at PC 17 (`inst` 8'hF7) with `cond_i` = 1, `reg_data_i` = 8 → next `pc_o` = 25. Same instruction with `cond_i` = 0 → next `pc_o` = 18.
- At PC 49 (`inst` 8'hB6) with `cond_i` = 1, `reg_data_i` = 38 → next `pc_o` = 11.
- Start at 95, no branches taken → PC steps 95..99. Halt at 99 → `done_o` = 1, `pc_o` stays 99, `inst_count_o` = 5. A new start with addr 100 clears `done_o` and `inst_count_o`.
- `stall_i` high for 3 cycles at PC 5 → `pc_o` = 5 and the counter are unchanged for 3 cycles, then advance to 6. A `start_i` pulse during RUN → no effect.
- Start at 254 with non-branch, non-halt instructions → PC goes 255 then 0, with `error_o` = 1 and `done_o` = 1. A `branchb` at PC 3 with offset 10 → PC 249, and `error_o` stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: state encoding, opcodes, widths.
package cpu_pkg;

  localparam int PC_W   = 8;
  localparam int INST_W = 8;

  // Full-byte halt opcode and 5-bit branch opcode prefixes (low 3 bits = register).
  localparam logic [7:0] OP_HALT   = 8'h88;
  localparam logic [4:0] OP_BR_FWD = 5'b11110;
  localparam logic [4:0] OP_BR_BWD = 5'b10110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC resolution for one retiring instruction.
// Branch targets wrap silently; only the sequential +1 path can overflow.
module next_pc_calc
  import cpu_pkg::OP_HALT;
  import cpu_pkg::OP_BR_FWD;
  import cpu_pkg::OP_BR_BWD;
#(
  parameter int PC_W = cpu_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [7:0]      inst_i,
  input  logic            cond_i,
  input  logic [7:0]      reg_data_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic            is_halt_o,
  output logic            seq_overflow_o
);

  logic [PC_W-1:0] offset;
  logic            take_fwd;
  logic            take_bwd;

  assign offset   = PC_W'(reg_data_i);
  assign take_fwd = (inst_i[7:3] == OP_BR_FWD) && cond_i;
  assign take_bwd = (inst_i[7:3] == OP_BR_BWD) && cond_i;

  // Pick the next address; halt keeps the PC on the halt instruction.
  always_comb begin
    next_pc_o      = pc_i + PC_W'(1);
    is_halt_o      = (inst_i == OP_HALT);
    seq_overflow_o = 1'b0;
    if (is_halt_o) begin
      next_pc_o = pc_i;
    end else if (take_fwd) begin
      next_pc_o = pc_i + offset;
    end else if (take_bwd) begin
      next_pc_o = pc_i - offset;
    end else begin
      next_pc_o      = pc_i + PC_W'(1);
      seq_overflow_o = (pc_i == {PC_W{1'b1}});
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM address, resolves
// relative branches and halt, and counts retired instructions.
//
// Handshake: start_i is a single-cycle request honoured only in IDLE or HALT;
// while RUN, inst_valid_o=1 marks inst_o as live and each cycle with
// stall_i=0 retires it (stall_i is the downstream not-ready).
module fetch_unit
  import cpu_pkg::state_e;
  import cpu_pkg::ST_IDLE;
  import cpu_pkg::ST_RUN;
  import cpu_pkg::ST_HALT;
#(
  parameter int PC_W  = cpu_pkg::PC_W,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [PC_W-1:0]  start_addr_i,
  input  logic             stall_i,
  input  logic [7:0]       inst_i,
  input  logic             cond_i,
  input  logic [7:0]       reg_data_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [7:0]       inst_o,
  output logic             inst_valid_o,
  output logic             done_o,
  output logic             error_o,
  output logic [CNT_W-1:0] inst_count_o
);

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             valid_q;
  logic             done_q;

  logic [PC_W-1:0]  next_pc;
  logic             is_halt;
  logic             seq_ovf;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .pc_i           (pc_q),
    .inst_i         (inst_i),
    .cond_i         (cond_i),
    .reg_data_i     (reg_data_i),
    .next_pc_o      (next_pc),
    .is_halt_o      (is_halt),
    .seq_overflow_o (seq_ovf)
  );

  // Saturating increment of the retired-instruction counter.
  assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Control FSM with PC, counter and registered status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!stall_i) begin
            cnt_q <= cnt_d;
            if (is_halt) begin
              state_q <= ST_HALT;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pc_q <= next_pc;
              if (seq_ovf) begin
                err_q   <= 1'b1;
                state_q <= ST_HALT;
                valid_q <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: begin
          // IDLE and HALT both accept a new launch.
          if (start_i) begin
            state_q <= ST_RUN;
            pc_q    <= start_addr_i;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_i;
  assign inst_valid_o = valid_q;
  assign done_o       = done_q;
  assign error_o      = err_q;
  assign inst_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed corner sequences, then
// randomized traffic against an arithmetic reference model.
module tb_fetch_unit;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;
  localparam int SAT_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic             start_i;
  logic [PC_W-1:0]  start_addr_i;
  logic             stall_i;
  logic [7:0]       inst_i;
  logic             cond_i;
  logic [7:0]       reg_data_i;
  logic [PC_W-1:0]  pc_o;
  logic [7:0]       inst_o;
  logic             inst_valid_o;
  logic             done_o;
  logic             error_o;
  logic [CNT_W-1:0] inst_count_o;

  logic [PC_W-1:0]  sat_pc;
  logic [7:0]       sat_inst_i;
  logic [7:0]       sat_inst_o;
  logic             sat_valid;
  logic             sat_done;
  logic             sat_err;
  logic [SAT_W-1:0] sat_cnt;

  logic [7:0] rom [0:255];
  assign inst_i     = rom[pc_o];
  assign sat_inst_i = rom[sat_pc];

  fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .start_addr_i(start_addr_i),
    .stall_i(stall_i), .inst_i(inst_i), .cond_i(cond_i), .reg_data_i(reg_data_i),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o), .done_o(done_o),
    .error_o(error_o), .inst_count_o(inst_count_o)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  fetch_unit #(.PC_W(PC_W), .CNT_W(SAT_W)) dut_sat (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .start_addr_i(start_addr_i),
    .stall_i(stall_i), .inst_i(sat_inst_i), .cond_i(cond_i), .reg_data_i(reg_data_i),
    .pc_o(sat_pc), .inst_o(sat_inst_o), .inst_valid_o(sat_valid), .done_o(sat_done),
    .error_o(sat_err), .inst_count_o(sat_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [7:0] pc, input logic v,
                              input logic d, input logic e, input logic [15:0] cnt);
    chk({tag, ".pc"}, 32'(pc_o), 32'(pc));
    chk({tag, ".valid"}, 32'(inst_valid_o), 32'(v));
    chk({tag, ".done"}, 32'(done_o), 32'(d));
    chk({tag, ".err"}, 32'(error_o), 32'(e));
    chk({tag, ".cnt"}, 32'(inst_count_o), 32'(cnt));
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 running, 2 finished
  int m_mode, m_pc, m_cnt;
  bit m_err;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic model_step();
    int ins, op5;
    ins = int'(rom[m_pc]);
    op5 = ins / 8;
    if (m_mode != 1) begin
      if (start_i) begin
        m_mode = 1; m_pc = int'(start_addr_i); m_cnt = 0; m_err = 0;
      end
    end else if (!stall_i) begin
      m_cnt++;
      if (ins == 136) m_mode = 2;
      else if (op5 == 30 && cond_i) m_pc = (m_pc + int'(reg_data_i)) % 256;
      else if (op5 == 22 && cond_i) m_pc = (m_pc - int'(reg_data_i) + 256) % 256;
      else if (m_pc + 1 > 255) begin
        m_pc = 0; m_err = 1; m_mode = 2;
      end else m_pc = m_pc + 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic [7:0] a, input logic st,
                       input logic c, input logic [7:0] r);
    start_i = s; start_addr_i = a; stall_i = st; cond_i = c; reg_data_i = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        start;
    logic [7:0]  addr;
    logic        stall;
    logic        cond;
    logic [7:0]  rd;
    logic [7:0]  exp_pc;
    logic [15:0] exp_cnt;
  } vec_t;

  function automatic vec_t mkv(logic s, logic [7:0] a, logic st, logic c, logic [7:0] r,
                               logic [7:0] pc, logic [15:0] cnt);
    vec_t v;
    v.start = s; v.addr = a; v.stall = st; v.cond = c; v.rd = r;
    v.exp_pc = pc; v.exp_cnt = cnt;
    return v;
  endfunction

  vec_t tbl[$];
  vec_t v;
  int   exp_sat;

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[17] = 8'hF7;
    rom[49] = 8'hB6;
    rom[99] = 8'h88;
    rom[3]  = 8'hB0;
    model_reset();
    #12;
    expect_state("reset", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst_ni = 1'b1;

    // ---- table: every row leaves the unit running ----
    tbl.push_back(mkv(1, 8'd16, 0, 0, 8'd0,  8'd16, 16'd0));
    tbl.push_back(mkv(0, 8'd0,  0, 0, 8'd0,  8'd17, 16'd1));
    tbl.push_back(mkv(0, 8'd0,  0, 1, 8'd8,  8'd25, 16'd2));
    tbl.push_back(mkv(0, 8'd0,  1, 1, 8'd8,  8'd25, 16'd2));
    tbl.push_back(mkv(1, 8'd0,  0, 0, 8'd0,  8'd26, 16'd3));
    tbl.push_back(mkv(0, 8'd0,  0, 1, 8'd22, 8'd27, 16'd4));
    tbl.push_back(mkv(1, 8'd9,  1, 0, 8'd0,  8'd27, 16'd4));
    tbl.push_back(mkv(0, 8'd0,  0, 0, 8'd0,  8'd28, 16'd5));
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.start, v.addr, v.stall, v.cond, v.rd);
      step();
      expect_state($sformatf("tbl%0d", i), v.exp_pc, 1'b1, 1'b0, 1'b0, v.exp_cnt);
      chk($sformatf("tbl%0d.inst", i), 32'(inst_o), 32'(rom[v.exp_pc]));
    end

    // ---- asynchronous reset while running at PC 37 ----
    do_reset();
    drive(1, 8'd35, 0, 0, 8'd0); step();
    drive(0, 8'd0, 0, 0, 8'd0); step(); step();
    expect_state("pre_rst", 8'd37, 1'b1, 1'b0, 1'b0, 16'd2);
    rst_ni = 1'b0;
    #1;
    expect_state("rst_mid", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst_ni = 1'b1;

    // ---- branch not taken, zero-offset self loop, backward branch ----
    drive(1, 8'd17, 0, 0, 8'd0); step();
    drive(0, 8'd0, 0, 0, 8'd8); step();
    expect_state("br_nt", 8'd18, 1'b1, 1'b0, 1'b0, 16'd1);
    do_reset();
    drive(1, 8'd17, 0, 0, 8'd0); step();
    drive(0, 8'd0, 0, 1, 8'd0); step();
    expect_state("self0", 8'd17, 1'b1, 1'b0, 1'b0, 16'd1);
    step();
    expect_state("self1", 8'd17, 1'b1, 1'b0, 1'b0, 16'd2);
    do_reset();
    drive(1, 8'd49, 0, 0, 8'd0); step();
    drive(0, 8'd0, 0, 1, 8'd38); step();
    expect_state("br_bwd", 8'd11, 1'b1, 1'b0, 1'b0, 16'd1);

    // ---- run 95..99, halt, restart at 100 ----
    do_reset();
    drive(1, 8'd95, 0, 0, 8'd0); step();
    expect_state("s95", 8'd95, 1'b1, 1'b0, 1'b0, 16'd0);
    drive(0, 8'd0, 0, 0, 8'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      expect_state($sformatf("seq%0d", i), 8'(95 + i), 1'b1, 1'b0, 1'b0, 16'(i));
    end
    step();
    expect_state("halt", 8'd99, 1'b0, 1'b1, 1'b0, 16'd5);
    drive(0, 8'd0, 1, 0, 8'd0); step();
    expect_state("halt_hold", 8'd99, 1'b0, 1'b1, 1'b0, 16'd5);
    drive(1, 8'd100, 0, 0, 8'd0); step();
    expect_state("restart", 8'd100, 1'b1, 1'b0, 1'b0, 16'd0);

    // ---- stall at PC 5, then ignored start ----
    do_reset();
    drive(1, 8'd4, 0, 0, 8'd0); step();
    drive(0, 8'd0, 0, 0, 8'd0); step();
    expect_state("st_pre", 8'd5, 1'b1, 1'b0, 1'b0, 16'd1);
    drive(0, 8'd0, 1, 0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_state($sformatf("stall%0d", i), 8'd5, 1'b1, 1'b0, 1'b0, 16'd1);
    end
    drive(0, 8'd0, 0, 0, 8'd0); step();
    expect_state("st_post", 8'd6, 1'b1, 1'b0, 1'b0, 16'd2);
    drive(1, 8'd50, 0, 0, 8'd0); step();
    expect_state("run_start", 8'd7, 1'b1, 1'b0, 1'b0, 16'd3);

    // ---- sequential overflow, then wrapping backward branch ----
    do_reset();
    drive(1, 8'd254, 0, 0, 8'd0); step();
    drive(0, 8'd0, 0, 0, 8'd0); step();
    expect_state("p255", 8'd255, 1'b1, 1'b0, 1'b0, 16'd1);
    step();
    expect_state("ovf", 8'd0, 1'b0, 1'b1, 1'b1, 16'd2);
    drive(1, 8'd3, 0, 0, 8'd0); step();
    expect_state("clr_err", 8'd3, 1'b1, 1'b0, 1'b0, 16'd0);
    drive(0, 8'd0, 0, 1, 8'd10); step();
    expect_state("br_wrap", 8'd249, 1'b1, 1'b0, 1'b0, 16'd1);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 39))
        0:       rom[i] = 8'h88;
        1,2,3,4,5,6,7,8:     rom[i] = 8'(8'hF0 | $urandom_range(0, 7));
        9,10,11,12,13,14,15: rom[i] = 8'(8'hB0 | $urandom_range(0, 7));
        default: rom[i] = 8'($urandom_range(0, 255));
      endcase
      if (rom[i] == 8'h88 && i % 7 != 0) rom[i] = 8'h01;
    end
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)));
      model_step();
      step();
      expect_state($sformatf("rnd%0d", c), 8'(m_pc), (m_mode == 1), (m_mode == 2), m_err,
                   16'((m_cnt > 65535) ? 65535 : m_cnt));
      exp_sat = (m_cnt > 7) ? 7 : m_cnt;
      chk($sformatf("rnd%0d.sat", c), 32'(sat_cnt), 32'(exp_sat));
      chk($sformatf("rnd%0d.inst", c), 32'(inst_o), 32'(rom[8'(m_pc)]));
      if ($urandom_range(0, 299) == 0) begin
        rst_ni = 1'b0;
        #1;
        model_reset();
        expect_state($sformatf("rnd_rst%0d", c), 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        rst_ni = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
